alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU; next generation of the single-cycle riscy32 ALU.
//  Executes RV base integer ops plus the optional M-extension (MUL/DIV/REM).
//  Operands enter over a valid/ready handshake; results leave over a second valid/ready handshake.
//  Sits between decode/operand-read and writeback; stalls the core via in_ready.
// PARAMETERS
//  XLEN   32  operand/result width (>=8, power of 2); SHW=$clog2(XLEN), CW=$clog2(XLEN+1) localparams
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst         in   1     synchronous, active-high reset
//  in_valid    in   1     operands/op valid
//  in_ready    out  1     unit can accept (IDLE, or DONE with out_ready=1)
//  op          in   4     {funct7[5],funct3} ALUControl encoding
//  op_m        in   1     1 = M-extension op, op[2:0]=funct3, op[3] ignored
//  rs1         in   XLEN  operand a
//  rs2         in   XLEN  operand b
//  out_valid   out  1     result valid, held until out_ready
//  out_ready   in   1     consumer accepts result
//  rd          out  XLEN  result
//  flags       out  4     {N,Z,C,V}: [3]=sign [2]=zero [1]=carry [0]=overflow
//  illegal     out  1     op not supported (with result), qualified by out_valid
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, rd=0, flags=0, illegal=0, counter=0. rst mid-op aborts; no result emitted.
//  FSM: IDLE -accept-> base op: DONE; MUL/DIV: BUSY. BUSY -count==XLEN-> DONE.
//       DONE -out_ready-> IDLE, or direct re-accept if in_valid (back-to-back).
//  Accept = in_valid & in_ready; operands/op latched on accept; inputs ignored otherwise.
//  Latency accept->out_valid: base ops 1 cycle; M ops XLEN+1 cycles (32 -> 33).
//  Base ops (op_m=0): 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR,
//   0101 SRL, 1101 SRA, 0110 OR, 0111 AND; any other code -> rd=0, illegal=1.
//  Shifts use rs2[SHW-1:0] only; SRA sign-fills.
//  ADD: C = carry-out bit XLEN; V = (a[msb]==b[msb]) & (r[msb]!=a[msb]).
//  SUB: computed a+~b+1; C = carry-out (1 when a>=b unsigned); V = (a[msb]!=b[msb]) & (r[msb]!=a[msb]).
//  All other ops: C=V=0. Z = (rd==0), N = rd[XLEN-1] for every op.
//  M ops (op_m=1): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  MUL*: radix-2 shift-add on magnitudes, 2*XLEN product, sign fixed at end; MUL low half, MULH* high.
//  DIV*/REM*: restoring division on magnitudes, quotient sign = a^b, remainder sign = a.
//  Div by zero: quotient all-ones, remainder = rs1, still XLEN+1 cycles.
//  Signed overflow (-2^(XLEN-1) / -1): quotient = rs1, remainder = 0.
//  rd/flags/illegal stable while out_valid=1 and out_ready=0.
// CONFIGURATION
//  ALU_MULDIV_EN defined: M-extension datapath and BUSY state built as above.
//  Not defined: no multiplier/divider logic; op_m=1 completes in 1 cycle with rd=0, flags=4'b0100, illegal=1.
// TESTING
//  1 ADD 20+30, out_ready=1 -> out_valid 1 cycle after accept, rd=50, flags=0000.
//  2 ADD 0x7FFFFFFF+1 -> rd=0x80000000, V=1, C=0, N=1; ADD 0xFFFFFFFF+1 -> rd=0, C=1, Z=1.
//  3 SUB 20-20 -> Z=1, C=1; SUB -2-30 -> rd=0xFFFFFFE0, N=1; SRA 0x80000000>>4 -> 0xF8000000.
//  4 MUL 7*-3 -> rd=0xFFFFFFEB at cycle 33; MULHU 0xFFFFFFFF*2 -> 1; DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
//  5 DIV 0x80000000/-1 -> 0x80000000; REM -> 0; hold out_ready=0 5 cycles -> rd stable, in_ready=0.
//  6 rst during BUSY cycle 10 -> out_valid=0 next cycle, in_ready=1; op=1111 base -> illegal=1, rd=0.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle integer ALU with separate input and output valid/ready handshakes.
// Base RV integer ops finish one cycle after accept.
// Build option ALU_MULDIV_EN adds an iterative M-extension datapath:
//   - radix-2 shift-add multiply;
//   - restoring divide;
//   - XLEN+1 cycles from accept to result.
// Without ALU_MULDIV_EN, M ops complete in one cycle and report illegal.
module alu_mc #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic            op_m,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic [3:0]      flags,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] rd_q, rd_d;
    logic [3:0]      flags_q, flags_d;
    logic            illegal_q, illegal_d;

    logic            accept_s;
    logic            go_busy_s;
    logic [XLEN+2:0] base_s;
    logic [XLEN-1:0] base_r_s;

    // Single-cycle base operation.
    // Returned packed as {illegal, carry, overflow, result}.
    function automatic logic [XLEN+2:0] base_alu(
        input logic [3:0]      f,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [XLEN:0]   sum;
        logic [XLEN-1:0] r;
        logic [SHW-1:0]  sh;
        logic            c;
        logic            v;
        logic            ill;
        sum = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        sh  = b[SHW-1:0];
        case (f)
            4'b0000: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[XLEN-1:0];
                c   = sum[XLEN];
                v   = (a[XLEN-1] == b[XLEN-1]) && (r[XLEN-1] != a[XLEN-1]);
            end
            4'b1000: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
                r   = sum[XLEN-1:0];
                c   = sum[XLEN];
                v   = (a[XLEN-1] != b[XLEN-1]) && (r[XLEN-1] != a[XLEN-1]);
            end
            4'b0001: r = a << sh;
            4'b0010: r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: r = {{(XLEN-1){1'b0}}, (a < b)};
            4'b0100: r = a ^ b;
            4'b0101: r = a >> sh;
            4'b1101: r = $unsigned($signed(a) >>> sh);
            4'b0110: r = a | b;
            4'b0111: r = a & b;
            default: ill = 1'b1;
        endcase
        return {ill, c, v, r};
    endfunction

    assign accept_s = in_valid & in_ready;
    assign base_s   = base_alu(op, rs1, rs2);
    assign base_r_s = base_s[XLEN-1:0];

`ifdef ALU_MULDIV_EN
    localparam int            CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

    // hi/lo hold the running product, or the remainder/quotient during a divide.
    // dvs holds the multiplicand magnitude or the divisor magnitude.
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        mop_q, mop_d;
    logic              neg_q, neg_d, rneg_q, rneg_d, div0_q, div0_d;

    logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic [XLEN:0]     mul_sum_s, div_rem_s;
    logic [XLEN-1:0]   div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s, rem_fix_s, m_res_s;

    assign go_busy_s = op_m;

    // Operand sign handling at accept time, plus the shift-add and restoring-divide steps.
    always_comb begin
        // Signed-operand selection.
        //   MUL, MULH:    both operands signed.
        //   MULHSU:       only rs1 signed.
        //   DIV, REM:     both operands signed.
        //   MULHU, DIVU, REMU: both operands unsigned.
        a_sgn_s    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_sgn_s    = op[2] ? ~op[0] : ~op[1];
        a_neg_s    = a_sgn_s & rs1[XLEN-1];
        b_neg_s    = b_sgn_s & rs2[XLEN-1];
        a_mag_s    = a_neg_s ? (~rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : rs1;
        b_mag_s    = b_neg_s ? (~rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : rs2;
        mul_sum_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
        div_rem_s  = {hi_q, lo_q[XLEN-1]};
        div_ge_s   = (div_rem_s >= {1'b0, dvs_q});
        div_diff_s = div_rem_s[XLEN-1:0] - dvs_q;
        prod_s     = {hi_q, lo_q};
        prod_fix_s = neg_q ? (~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_s;
        // Divide by zero already leaves rs1 as the remainder.
        // Only the quotient needs forcing to all-ones.
        quo_fix_s  = div0_q ? {XLEN{1'b1}}
                            : (neg_q ? (~lo_q + {{(XLEN-1){1'b0}}, 1'b1}) : lo_q);
        rem_fix_s  = rneg_q ? (~hi_q + {{(XLEN-1){1'b0}}, 1'b1}) : hi_q;
        case (mop_q)
            3'b000:  m_res_s = prod_fix_s[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  m_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  m_res_s = quo_fix_s;
            default: m_res_s = rem_fix_s;
        endcase
    end
`else
    assign go_busy_s = 1'b0;
`endif

    // Next-value logic for the result registers and the iterative datapath.
    always_comb begin
        rd_d      = rd_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
        hi_d      = hi_q;
        lo_d      = lo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        mop_d     = mop_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        div0_d    = div0_q;
`endif
        if (accept_s) begin
            if (op_m) begin
`ifdef ALU_MULDIV_EN
                hi_d   = '0;
                lo_d   = a_mag_s;
                dvs_d  = b_mag_s;
                cnt_d  = '0;
                mop_d  = op[2:0];
                neg_d  = a_neg_s ^ b_neg_s;
                rneg_d = a_neg_s;
                div0_d = (rs2 == {XLEN{1'b0}});
`else
                rd_d      = '0;
                flags_d   = 4'b0100;
                illegal_d = 1'b1;
`endif
            end else begin
                rd_d      = base_r_s;
                flags_d   = {base_r_s[XLEN-1], (base_r_s == {XLEN{1'b0}}), base_s[XLEN+1], base_s[XLEN]};
                illegal_d = base_s[XLEN+2];
            end
        end else begin
            rd_d = rd_q;
        end
`ifdef ALU_MULDIV_EN
        if (state_q == S_BUSY) begin
            if (cnt_q == CNT_LAST) begin
                rd_d      = m_res_s;
                flags_d   = {m_res_s[XLEN-1], (m_res_s == {XLEN{1'b0}}), 2'b00};
                illegal_d = 1'b0;
            end else if (!mop_q[2]) begin
                {hi_d, lo_d} = {mul_sum_s, lo_q[XLEN-1:1]};
                cnt_d        = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                hi_d  = div_ge_s ? div_diff_s : div_rem_s[XLEN-1:0];
                lo_d  = {lo_q[XLEN-2:0], div_ge_s};
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = cnt_d;
        end
`endif
    end

    // Datapath and result registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= '0;
            flags_q   <= 4'b0000;
            illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
            hi_q      <= '0;
            lo_q      <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            mop_q     <= 3'b000;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            rd_q      <= rd_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            mop_q     <= mop_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            div0_q    <= div0_d;
`endif
        end
    end

    // FSM state register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    // From DONE, a pending input is accepted directly for back-to-back issue.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = go_busy_s ? S_BUSY : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
`endif
            S_DONE: begin
                if (accept_s) begin
                    state_d = go_busy_s ? S_BUSY : S_DONE;
                end else if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake signals decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_DONE: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    assign rd      = rd_q;
    assign flags   = flags_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (XLEN=32).
// Expected values are hand-computed.
// The M-extension vectors follow the ALU_MULDIV_EN build option.
module tb_alu_mc;
    localparam int XLEN = 32;
    localparam int TMO  = 100;
`ifdef ALU_MULDIV_EN
    localparam int MLAT = XLEN + 1;
`else
    localparam int MLAT = 1;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic            op_m;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;
    logic [3:0]      flags;
    logic            illegal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        m;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_mc #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_m      (op_m),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic m, input logic [3:0] o,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic [3:0] f,
                                input logic ill, input int lat);
        vec_t v;
        v.name = n; v.m = m; v.op = o; v.a = a; v.b = b;
        v.r = r; v.f = f; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < TMO);
        if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        op = v.op; op_m = v.m; rs1 = v.a; rs2 = v.b;
        in_valid = 1'b1; out_ready = 1'b1;
        chk({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678; op = 4'b0000;
        wait_valid(lat);
        chk({v.name, "_latency"}, lat, v.lat);
        chk({v.name, "_rd"}, rd, v.r);
        chk({v.name, "_flags"}, {28'd0, flags}, {28'd0, v.f});
        chk({v.name, "_illegal"}, {31'd0, illegal}, {31'd0, v.ill});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen;

        // Base-op vectors: {name, op_m, op, a, b, rd, flags NZCV, illegal, latency}.
        add("add_basic",  1'b0, 4'b0000, 32'd20,        32'd30,        32'd50,        4'b0000, 1'b0, 1);
        add("add_ovf",    1'b0, 4'b0000, 32'h7FFFFFFF,  32'd1,         32'h80000000,  4'b1001, 1'b0, 1);
        add("add_carry",  1'b0, 4'b0000, 32'hFFFFFFFF,  32'd1,         32'h00000000,  4'b0110, 1'b0, 1);
        add("sub_zero",   1'b0, 4'b1000, 32'd20,        32'd20,        32'h00000000,  4'b0110, 1'b0, 1);
        add("sub_neg",    1'b0, 4'b1000, 32'hFFFFFFFE,  32'd30,        32'hFFFFFFE0,  4'b1010, 1'b0, 1);
        add("sub_borrow", 1'b0, 4'b1000, 32'd1,         32'd2,         32'hFFFFFFFF,  4'b1000, 1'b0, 1);
        add("sub_ovf",    1'b0, 4'b1000, 32'h80000000,  32'd1,         32'h7FFFFFFF,  4'b0011, 1'b0, 1);
        add("sra",        1'b0, 4'b1101, 32'h80000000,  32'd4,         32'hF8000000,  4'b1000, 1'b0, 1);
        add("srl_mask",   1'b0, 4'b0101, 32'h80000000,  32'h24,        32'h08000000,  4'b0000, 1'b0, 1);
        add("sll",        1'b0, 4'b0001, 32'd1,         32'd31,        32'h80000000,  4'b1000, 1'b0, 1);
        add("slt",        1'b0, 4'b0010, 32'hFFFFFFFF,  32'd1,         32'd1,         4'b0000, 1'b0, 1);
        add("sltu",       1'b0, 4'b0011, 32'hFFFFFFFF,  32'd1,         32'd0,         4'b0100, 1'b0, 1);
        add("xor",        1'b0, 4'b0100, 32'h0000F0F0,  32'h0000FF00,  32'h00000FF0,  4'b0000, 1'b0, 1);
        add("or",         1'b0, 4'b0110, 32'h0000F0F0,  32'h00000F0F,  32'h0000FFFF,  4'b0000, 1'b0, 1);
        add("and",        1'b0, 4'b0111, 32'h0000F0F0,  32'h0000FF00,  32'h0000F000,  4'b0000, 1'b0, 1);
        add("illegal_op", 1'b0, 4'b1111, 32'd5,         32'd6,         32'd0,         4'b0100, 1'b1, 1);
`ifdef ALU_MULDIV_EN
        add("mul",        1'b1, 4'b0000, 32'd7,         32'hFFFFFFFD,  32'hFFFFFFEB,  4'b1000, 1'b0, MLAT);
        add("mulh",       1'b1, 4'b0001, 32'h80000000,  32'd2,         32'hFFFFFFFF,  4'b1000, 1'b0, MLAT);
        add("mulhsu",     1'b1, 4'b0010, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  4'b1000, 1'b0, MLAT);
        add("mulhu",      1'b1, 4'b0011, 32'hFFFFFFFF,  32'd2,         32'd1,         4'b0000, 1'b0, MLAT);
        add("div_by0",    1'b1, 4'b0100, 32'd7,         32'd0,         32'hFFFFFFFF,  4'b1000, 1'b0, MLAT);
        add("rem_by0",    1'b1, 4'b0110, 32'd7,         32'd0,         32'd7,         4'b0000, 1'b0, MLAT);
        add("div_neg_0",  1'b1, 4'b0100, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  4'b1000, 1'b0, MLAT);
        add("rem_neg_0",  1'b1, 4'b0110, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  4'b1000, 1'b0, MLAT);
        add("div_ovf",    1'b1, 4'b0100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  4'b1000, 1'b0, MLAT);
        add("rem_ovf",    1'b1, 4'b0110, 32'h80000000,  32'hFFFFFFFF,  32'd0,         4'b0100, 1'b0, MLAT);
        add("div_signed", 1'b1, 4'b0100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  4'b1000, 1'b0, MLAT);
        add("rem_signed", 1'b1, 4'b0110, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  4'b1000, 1'b0, MLAT);
        add("divu",       1'b1, 4'b0101, 32'd100,       32'd7,         32'd14,        4'b0000, 1'b0, MLAT);
        add("remu",       1'b1, 4'b0111, 32'd100,       32'd7,         32'd2,         4'b0000, 1'b0, MLAT);
        add("divu_by0",   1'b1, 4'b0101, 32'hFFFFFFFF,  32'd0,         32'hFFFFFFFF,  4'b1000, 1'b0, MLAT);
`else
        add("m_mul_off",  1'b1, 4'b0000, 32'd7,         32'd3,         32'd0,         4'b0100, 1'b1, MLAT);
        add("m_div_off",  1'b1, 4'b0100, 32'd7,         32'd0,         32'd0,         4'b0100, 1'b1, MLAT);
`endif

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'b0000; op_m = 1'b0;
        rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_rd",        rd,                 32'd0);
        chk("reset_flags",     {28'd0, flags},     32'd0);
        chk("reset_illegal",   {31'd0, illegal},   32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Result held stable while the consumer stalls.
        // An input offered during the stall must be ignored.
        @(negedge clk);
        out_ready = 1'b0;
        op = 4'b0000; op_m = 1'b0; rs1 = 32'h7FFFFFFF; rs2 = 32'd1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        rs1 = 32'd3; rs2 = 32'd4;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
            chk("hold_rd",        rd,                 32'h80000000);
            chk("hold_flags",     {28'd0, flags},     {28'd0, 4'b1001});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", {31'd0, out_valid}, 32'd0);

        // Back-to-back issue: a new op is accepted while the previous result drains.
        op = 4'b0000; rs1 = 32'd1; rs2 = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        op = 4'b1000; rs1 = 32'd10; rs2 = 32'd3;
        @(negedge clk);
        chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_first_rd",    rd,                 32'd3);
        chk("b2b_in_ready",    {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_second_rd",    rd,                 32'd7);
        @(negedge clk);
        chk("b2b_drain_valid",  {31'd0, out_valid}, 32'd0);

        // Reset while an operation is in flight.
        // No result may appear afterwards.
`ifdef ALU_MULDIV_EN
        op = 4'b0000; op_m = 1'b1; rs1 = 32'd9; rs2 = 32'd9; out_ready = 1'b1;
`else
        op = 4'b0000; op_m = 1'b0; rs1 = 32'd9; rs2 = 32'd9; out_ready = 1'b0;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
        chk("abort_rd",        rd,                 32'd0);
        chk("abort_flags",     {28'd0, flags},     32'd0);
        rst = 1'b0; op_m = 1'b0; out_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_result", {31'd0, seen}, 32'd0);

        // Unit is usable again after the abort.
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
